uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first: the receive end of the 8N1 link driven by the team's UART transmitter. Sits between the asynchronous `rx` pin and the preprocessing datapath. Synchronises the line, centre-samples each bit, and presents each byte in a holding register with a valid/ack handshake. Reports framing and overrun errors.

## Interface
- `CLOCK_FREQ`, 50000000: system clock in Hz.
- `BAUD_RATE`, 115200: line rate in baud. `CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE` (434 at defaults); `HALF_BIT = CLKS_PER_BIT/2` (217).
- `clk  in  1`: system clock, rising edge.
- `reset  in  1`: **one clock; reset is synchronous and active-high.**
- `rx  in  1`: asynchronous UART line, idle high.
- `data_out  out  8`: last received byte; reset 0.
- `rx_valid  out  1`: `data_out` holds an unconsumed byte; reset 0.
- `rx_ack  in  1`: consumer accepts `data_out`; ignored while `rx_valid`=0.
- `frame_err  out  1`: one-cycle pulse when the stop bit samples low; reset 0.
- `overrun  out  1`: sticky; a byte arrived while `rx_valid`=1; reset 0.
- `busy  out  1`: FSM not in IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchroniser producing `rx_s`. Synchroniser flops reset to 1.
- FSM states: IDLE, START, DATA, STOP, BREAK_WAIT. Reset enters IDLE with counter 0, bit index 0, shift register 0.
- IDLE: if `rx_s`=0, go to START with counter cleared.
- START: count to `HALF_BIT-1`, then sample. Low: go to DATA with counter and bit index cleared. High: treat as a glitch and return to IDLE; no flags.
- DATA: count to `CLKS_PER_BIT-1`, then sample into shift register bit[bit_index] (LSB first) and clear the counter. After bit 7, go to STOP.
- STOP: count to `CLKS_PER_BIT-1`, then sample.
  - High: load `data_out`, set `rx_valid`, go to IDLE.
  - Low: pulse `frame_err`, discard the byte (`data_out` and `rx_valid` unchanged), go to BREAK_WAIT.
- BREAK_WAIT: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering START.
- Handshake:
  - `rx_ack` while `rx_valid`=1 clears `rx_valid` and `overrun` on the next edge.
  - If a new byte completes while `rx_valid`=1 and `rx_ack`=0: `data_out` is overwritten, `rx_valid` stays 1, `overrun` is set.
  - If a new byte completes in the same cycle as `rx_ack`: the completion wins. `rx_valid` stays 1, `data_out` takes the new byte, `overrun` is cleared (the old byte was consumed).
- Counter is 16 bits and must satisfy `CLKS_PER_BIT` < 65536.
- Reset asserted mid-frame aborts the frame with no flags; the partial byte is lost.

## Timing
- Input latency: 2 cycles (synchroniser).
- `rx_valid` rises `2 + HALF_BIT + 9*CLKS_PER_BIT + 1` cycles after the `rx` falling edge of the start bit: 4126 at defaults. Bench tolerance is ±2 cycles.
- `frame_err` pulses in the same cycle position in which `rx_valid` would rise.
- Back-to-back frames are accepted: IDLE is re-entered about 0.5 bit before the stop bit ends, so the next start edge is caught.
- `busy` is high from the cycle after start detection until the return to IDLE.
- No combinational path from `rx` or `rx_ack` to any output.

## Configuration
- `UART_RX_MAJORITY_EN` defined: a 3-deep history of `rx_s` is kept, and every sample (start, data, stop) is the 2-of-3 majority of the `rx_s` values at counter, counter-1 and counter-2. Output latency is unchanged.
- Undefined: each sample is the single `rx_s` value at the sample cycle.

## Structure
- `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK_WAIT), 3 bits.
  - `UART_DATA_BITS` = 8.
  - Function `clks_per_bit(freq, baud)`.
- Sub-module `uart_rx_sampler`: the synchroniser plus the optional majority window. Outputs `rx_s` and `rx_bit`; `UART_RX_MAJORITY_EN` is confined to it.
- Top-level holds the FSM, counters, shift register and handshake logic.

## Test plan
- Send 0xA5 at 115200 with `rx_ack` held 0: `rx_valid` rises at 4126±2 cycles, `data_out`=0xA5, no errors. Pulse `rx_ack`: `rx_valid` falls.
- Glitch: `rx` low for 100 cycles, then high: FSM returns to IDLE, `busy` drops within 220 cycles, no `rx_valid`, no `frame_err`.
- Frame 0x3C with the stop bit driven low, then `rx` held low for 5 bit periods, then high: one `frame_err` pulse, `rx_valid` stays 0, FSM remains in BREAK_WAIT until `rx` returns high, no spurious byte afterwards.
- Send 0x11 then 0x22 back-to-back with no ack: `data_out`=0x22, `rx_valid`=1, `overrun`=1. `rx_ack` clears both flags.
- Assert `rx_ack` in exactly the cycle the second byte completes: `rx_valid`=1, `data_out`=second byte, `overrun`=0.
- Assert `reset` in the middle of data bit 4: all outputs return to reset values next edge. The following clean frame 0xFF is received correctly. With `UART_RX_MAJORITY_EN` defined, a 1-cycle low spike at a data-bit centre is rejected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receive path.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioner: 2-flop synchroniser (2 cycles), optional 2-of-3 majority sample
// when UART_RX_MAJORITY_EN is defined; no flow control, always accepts the line.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rx_bit
);

  logic rx_meta;

  // Idle-high reset keeps the FSM from seeing a false start edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  // Window is the current synchronised value plus the two before it, so a
  // one-cycle spike at the sample point is outvoted without adding latency.
  assign rx_bit = majority3(rx_s, rx_hist[0], rx_hist[1]);
`else
  assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver with holding register, valid/ack handshake, framing/overrun flags.
// rx_valid rises 2+HALF_BIT+9*CLKS_PER_BIT+1 cycles after the start edge; no stall, unacked bytes are overwritten (overrun).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam int          IDX_W     = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_rx_state_t             state;
  logic [15:0]                cnt;
  logic [IDX_W-1:0]           bit_idx;
  logic [UART_DATA_BITS-1:0]  shift_reg;
  logic                       rx_s;
  logic                       rx_bit;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rx_s   (rx_s),
    .rx_bit (rx_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_bit) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_bit;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_bit) begin
              // Completion overrides a same-cycle ack: the old byte counts as
              // consumed, so overrun is only raised when nobody took it.
              data_out <= shift_reg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        BREAK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default 50 MHz / 115200 baud.
module tb_uart_receiver;

  localparam int C   = 434;
  localparam int H   = 217;
  localparam int LAT = 2 + H + 9 * C + 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx       = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   rises    = 0;
  int   rise_cyc = 0;
  int   fe_cnt   = 0;
  int   fe_cyc   = 0;
  logic prev_valid = 1'b0;
  int   t0, r0, f0;

  uart_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rises    = rises + 1;
      rise_cyc = cyc;
    end
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte 0xA5, latency and handshake
    r0 = rises; f0 = fe_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    chk("a5_rises", 32'(rises - r0), 32'd1);
    chk_range("a5_latency", rise_cyc - t0, LAT - 2, LAT + 2);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_valid", 32'(rx_valid), 32'h1);
    chk("a5_ovr", 32'(overrun), 32'h0);
    chk("a5_ferr", 32'(fe_cnt - f0), 32'd0);
    chk("a5_busy_idle", 32'(busy), 32'h0);
    ack_pulse();
    chk("a5_ack_clr", 32'(rx_valid), 32'h0);

    // Start-bit glitch
    r0 = rises; f0 = fe_cnt;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (220) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_no_byte", 32'(rises - r0), 32'd0);
    chk("glitch_no_ferr", 32'(fe_cnt - f0), 32'd0);

    // Framing error followed by a 5-bit break
    r0 = rises; f0 = fe_cnt; t0 = cyc;
    send_frame(8'h3C, 1'b0);
    repeat (5 * C) @(negedge clk);
    chk("brk_ferr_cnt", 32'(fe_cnt - f0), 32'd1);
    chk_range("brk_ferr_time", fe_cyc - t0, LAT - 2, LAT + 2);
    chk("brk_valid", 32'(rx_valid), 32'h0);
    chk("brk_busy_hold", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("brk_busy_rel", 32'(busy), 32'h0);
    repeat (2 * C) @(negedge clk);
    chk("brk_no_byte", 32'(rises - r0), 32'd0);
    chk("brk_ferr_once", 32'(fe_cnt - f0), 32'd1);

    // Back-to-back without ack: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    ack_pulse();
    chk("ovr_ack_valid", 32'(rx_valid), 32'h0);
    chk("ovr_ack_flag", 32'(overrun), 32'h0);

    // Ack in the exact completion cycle of the second byte
    send_frame(8'h5A, 1'b1);
    chk("race_first", 32'(data_out), 32'h5A);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    chk("race_valid", 32'(rx_valid), 32'h1);
    chk("race_data", 32'(data_out), 32'hC3);
    chk("race_ovr", 32'(overrun), 32'h0);
    ack_pulse();

    // Reset in the middle of data bit 4
    r0 = rises; f0 = fe_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (H + 5 * C) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_valid", 32'(rx_valid), 32'h0);
        chk("mid_rst_ovr", 32'(overrun), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
      end
    join
    repeat (C) @(negedge clk);
    chk("mid_no_byte", 32'(rises - r0), 32'd0);
    chk("mid_no_ferr", 32'(fe_cnt - f0), 32'd0);
    send_frame(8'hFF, 1'b1);
    chk("ff_data", 32'(data_out), 32'hFF);
    chk("ff_valid", 32'(rx_valid), 32'h1);
    ack_pulse();

`ifdef UART_RX_MAJORITY_EN
    // One-cycle low spike landing on the data bit 2 sample point
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (H + 3 * C) @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
      end
    join
    chk("maj_data", 32'(data_out), 32'hFF);
    chk("maj_valid", 32'(rx_valid), 32'h1);
    ack_pulse();
`endif

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
